// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel, W-bit round-robin stream multiplexer.
//
// A fair arbiter picks one valid input channel per cycle and captures its
// beat into a registered output stage with valid/ready handshaking.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   per-channel valid                  [N]
//   in_data    channel i at bits [i*W +: W]       [N*W]
//   in_last    per-channel end-of-packet flag     [N] (lock build only)
//   in_ready   per-channel ready, one-hot or zero [N]
//   out_valid  output register holds a beat
//   out_data   registered beat data               [W]
//   out_chan   channel index of the held beat     [IW]
//   out_ready  consumer accepts the held beat
//
// Optional feature macro: MUX_PKT_LOCK_EN
//   Defined: after a beat with in_last=0 the arbiter stays on that channel
//   until its in_last=1 beat is accepted (no interleaving, bubbles allowed).
//   Undefined: in_last is ignored and arbitration is per beat.

module rr_stream_mux #(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_last,
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [IW-1:0]    out_chan,
    input  logic             out_ready
);

    logic [IW-1:0]  ptr_q, ptr_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic [IW-1:0]  out_chan_q, out_chan_d;

    logic [N-1:0]   req;
    logic           any_req;
    logic           load;
    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;
    int             first;
    int             gsum;
    logic [IW-1:0]  gnt;
    logic [N-1:0]   gnt_oh;
    logic [W-1:0]   sel_data;

`ifdef MUX_PKT_LOCK_EN
    logic lock_q, lock_d;

    // While locked, only the channel held in ptr may compete; ptr always
    // equals the locked channel because it is updated on every accept.
    always_comb begin
        req = in_valid;
        if (lock_q) begin
            req = in_valid & ({{(N-1){1'b0}}, 1'b1} << ptr_q);
        end
    end

    always_comb begin
        lock_d = lock_q;
        if (load && any_req) begin
            lock_d = ~in_last[gnt];
        end
    end
`else
    logic unused_last;
    assign unused_last = ^in_last;
    assign req         = in_valid;
`endif

    assign any_req = |req;
    assign load    = ~out_valid_q | out_ready;

    // Rotate requests so bit 0 is channel ptr+1; the lowest set bit of the
    // rotated vector is then the round-robin winner. Duplicating req makes
    // the rotation a plain right shift with no modulo logic.
    always_comb begin
        req2  = {req, req} >> (int'(ptr_q) + 1);
        rot   = req2[N-1:0];
        first = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) first = j;
        end
        gsum = int'(ptr_q) + 1 + first;
        if (gsum >= N) gsum = gsum - N;
        gnt = IW'(gsum);
        for (int i = 0; i < N; i++) begin
            gnt_oh[i] = any_req && (gsum == i);
        end
    end

    // One-hot AND-OR data select.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            sel_data = sel_data | (in_data[i*W +: W] & {W{gnt_oh[i]}});
        end
    end

    assign in_ready = gnt_oh & {N{load & ~reset}};

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = any_req;
            if (any_req) begin
                out_data_d = sel_data;
                out_chan_d = gnt;
                ptr_d      = gnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= IW'(N - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

`ifdef MUX_PKT_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) lock_q <= 1'b0;
        else       lock_q <= lock_d;
    end
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Testbench for rr_stream_mux: a 4x8 instance (table vectors, directed
// corner cases, randomized traffic against a queue-level model) and a
// 3x16 instance (wrap-around and index range).

module tb_rr_stream_mux;

    logic        clk;
    logic        reset;

    logic [3:0]  a_in_valid, a_in_last, a_in_ready;
    logic [31:0] a_in_data;
    logic        a_out_valid, a_out_ready;
    logic [7:0]  a_out_data;
    logic [1:0]  a_out_chan;

    logic [2:0]  b_in_valid, b_in_last, b_in_ready;
    logic [47:0] b_in_data;
    logic        b_out_valid, b_out_ready;
    logic [15:0] b_out_data;
    logic [1:0]  b_out_chan;

    int checks = 0;
    int errors = 0;

    rr_stream_mux #(.N(4), .W(8)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_last(a_in_last),
        .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_chan(a_out_chan),
        .out_ready(a_out_ready)
    );

    rr_stream_mux #(.N(3), .W(16)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_last(b_in_last),
        .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_chan(b_out_chan),
        .out_ready(b_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0]  v;
        logic        ordy;
        logic [31:0] d;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [1:0]  exp_ch;
        logic [7:0]  exp_d;
    } vec_t;

    vec_t tbl[15];

    // Random-phase model state (channel-level view of the rules).
    int         m_ptr;
    bit         m_locked;
    bit         m_ov;
    logic [7:0] m_od;
    int         m_oc;
    bit         pend[4];
    logic [7:0] pdata[4];
    bit         plast[4];

    int exp_lock[5];
    int c1;
    bit took1;

    initial begin
        localparam logic [31:0] D0  = 32'hA3A2A1A0;
        localparam logic [31:0] D5C = 32'hA35CA1A0;
        localparam logic [31:0] D5D = 32'hA35DA1A0;

        tbl[0]  = '{4'b1111, 1'b1, D0,  4'b0001, 1'b1, 2'd0, 8'hA0};
        tbl[1]  = '{4'b1111, 1'b1, D0,  4'b0010, 1'b1, 2'd1, 8'hA1};
        tbl[2]  = '{4'b1111, 1'b1, D0,  4'b0100, 1'b1, 2'd2, 8'hA2};
        tbl[3]  = '{4'b1111, 1'b1, D0,  4'b1000, 1'b1, 2'd3, 8'hA3};
        tbl[4]  = '{4'b1111, 1'b1, D0,  4'b0001, 1'b1, 2'd0, 8'hA0};
        tbl[5]  = '{4'b0010, 1'b1, D0,  4'b0010, 1'b1, 2'd1, 8'hA1};
        tbl[6]  = '{4'b1001, 1'b1, D0,  4'b1000, 1'b1, 2'd3, 8'hA3};
        tbl[7]  = '{4'b1001, 1'b1, D0,  4'b0001, 1'b1, 2'd0, 8'hA0};
        tbl[8]  = '{4'b0000, 1'b1, D0,  4'b0000, 1'b0, 2'd0, 8'h00};
        tbl[9]  = '{4'b0100, 1'b0, D5C, 4'b0100, 1'b1, 2'd2, 8'h5C};
        tbl[10] = '{4'b0100, 1'b0, D5C, 4'b0000, 1'b1, 2'd2, 8'h5C};
        tbl[11] = '{4'b0100, 1'b0, D5C, 4'b0000, 1'b1, 2'd2, 8'h5C};
        tbl[12] = '{4'b0100, 1'b1, D5D, 4'b0100, 1'b1, 2'd2, 8'h5D};
        tbl[13] = '{4'b0000, 1'b0, D5D, 4'b0000, 1'b1, 2'd2, 8'h5D};
        tbl[14] = '{4'b0000, 1'b1, D5D, 4'b0000, 1'b0, 2'd0, 8'h00};

`ifdef MUX_PKT_LOCK_EN
        exp_lock = '{1, 1, 1, 2, 0};
`else
        exp_lock = '{1, 2, 0, 1, 2};
`endif

        reset       = 1'b1;
        a_in_valid  = 4'b1111;
        a_in_data   = D0;
        a_in_last   = 4'b1111;
        a_out_ready = 1'b1;
        b_in_valid  = '0;
        b_in_data   = '0;
        b_in_last   = '1;
        b_out_ready = 1'b1;

        // Reset with all channels requesting.
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_out_valid", 32'(a_out_valid), 32'd0);
            chk("rst_in_ready", 32'(a_in_ready), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Table: round robin, fairness after idle, backpressure.
        for (int r = 0; r < 15; r++) begin
            a_in_valid  = tbl[r].v;
            a_out_ready = tbl[r].ordy;
            a_in_data   = tbl[r].d;
            #1 chk($sformatf("tbl%0d_in_ready", r), 32'(a_in_ready), 32'(tbl[r].exp_rdy));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_out_valid", r), 32'(a_out_valid), 32'(tbl[r].exp_ov));
            if (tbl[r].exp_ov) begin
                chk($sformatf("tbl%0d_out_chan", r), 32'(a_out_chan), 32'(tbl[r].exp_ch));
                chk($sformatf("tbl%0d_out_data", r), 32'(a_out_data), 32'(tbl[r].exp_d));
            end
            @(negedge clk);
        end

        // Reset mid-transfer discards the held beat and blocks in_ready.
        a_in_valid  = 4'b0001;
        a_out_ready = 1'b0;
        @(posedge clk); #1;
        chk("mid_load_valid", 32'(a_out_valid), 32'd1);
        @(negedge clk);
        reset       = 1'b1;
        a_out_ready = 1'b1;
        #1 chk("mid_rst_in_ready", 32'(a_in_ready), 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
        @(negedge clk);
        reset      = 1'b0;
        a_in_valid = '0;

        // N=3 instance: ch2 then wrap to ch0.
        b_in_data  = {16'hC2C2, 16'hC1C1, 16'hC0C0};
        b_in_valid = 3'b100;
        #1 chk("b_rdy_ch2", 32'(b_in_ready), 32'b100);
        @(posedge clk); #1;
        chk("b_chan_2", 32'(b_out_chan), 32'd2);
        chk("b_data_2", 32'(b_out_data), 32'hC2C2);
        @(negedge clk);
        b_in_valid = 3'b101;
        #1 chk("b_rdy_wrap", 32'(b_in_ready), 32'b001);
        @(posedge clk); #1;
        chk("b_chan_wrap", 32'(b_out_chan), 32'd0);
        chk("b_data_wrap", 32'(b_out_data), 32'hC0C0);
        @(negedge clk);
        b_in_valid = '0;

        // Packet lock: ptr=0 first, then ch0..ch2 all valid, ch1 has a
        // 3-beat packet.
        a_in_valid = 4'b0001;
        a_in_last  = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        c1 = 0;
        for (int k = 0; k < 5; k++) begin
            a_in_valid = 4'b0111;
            a_in_last  = {1'b1, 1'b1, (c1 == 2), 1'b1};
            a_in_data  = {8'hA3, 8'hA2, 8'(8'hB0 + c1), 8'hA0};
            #1 took1 = a_in_ready[1];
            @(posedge clk); #1;
            chk($sformatf("lock_seq%0d_chan", k), 32'(a_out_chan), 32'(exp_lock[k]));
            if (took1) c1++;
            @(negedge clk);
        end
        a_in_valid = '0;
        a_in_last  = '1;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic against the model; producers hold until accepted.
        m_ptr = 3; m_locked = 0; m_ov = 0; m_od = '0; m_oc = 0;
        for (int i = 0; i < 4; i++) begin
            pend[i] = 0; pdata[i] = '0; plast[i] = 1;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            int  g;
            bit  ld;
            logic [3:0] erdy;
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]  = 1;
                    pdata[i] = 8'($urandom);
                    plast[i] = ($urandom_range(0, 2) == 0);
                end
                a_in_valid[i]       = pend[i];
                a_in_data[i*8 +: 8] = pdata[i];
                a_in_last[i]        = plast[i];
            end
            a_out_ready = ($urandom_range(0, 3) != 0);
            b_in_valid  = 3'($urandom);
            b_in_last   = 3'($urandom);
            b_in_data   = {16'($urandom), 16'($urandom), 16'($urandom)};
            b_out_ready = ($urandom_range(0, 2) != 0);

            ld = !m_ov || a_out_ready;
            g  = -1;
            if (m_locked) begin
                if (pend[m_ptr]) g = m_ptr;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    if (g < 0 && pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
                end
            end
            erdy = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
            #1;
            chk("rnd_in_ready", 32'(a_in_ready), 32'(erdy));
            chk("b_rdy_legal", 32'(($countones(b_in_ready) <= 1) && ((b_in_ready & ~b_in_valid) == 0)), 32'd1);

            @(posedge clk);
            if (ld) begin
                if (g >= 0) begin
                    m_ov  = 1;
                    m_od  = pdata[g];
                    m_oc  = g;
                    m_ptr = g;
`ifdef MUX_PKT_LOCK_EN
                    m_locked = !plast[g];
`endif
                    pend[g] = 0;
                end else begin
                    m_ov = 0;
                end
            end
            #1;
            chk("rnd_out_valid", 32'(a_out_valid), 32'(m_ov));
            if (m_ov) begin
                chk("rnd_out_chan", 32'(a_out_chan), 32'(m_oc));
                chk("rnd_out_data", 32'(a_out_data), 32'(m_od));
            end
            if (b_out_valid) chk("b_chan_range", 32'(b_out_chan < 2'd3), 32'd1);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
